// File: rtl/window_tx.sv
`default_nettype none
// ============================================================================
// Module      : window_tx
// Description : Raster-to-3x3-window serializer. Accepts a row-major pixel
//               stream, keeps the pixels needed to form a 3x3 neighbourhood,
//               and for every complete window sends its nine pixels, one per
//               cycle, to a downstream median filter. It then waits for that
//               filter's result strobe before accepting the next pixel.
//
// Ports       : CLK    in   clock, rising edge
//               RST    in   asynchronous active-high reset
//               PI     in   [WIDTH]  incoming raster pixel
//               PVALID in   PI valid
//               PREADY out  pixel accepted when PVALID & PREADY
//               DO     out  [WIDTH]  serialized window pixel (0 when DSO=0)
//               DSO    out  window data strobe
//               ACK    in   result strobe from the median filter
//               LAST   out  high with DSO for the final window of a frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module window_tx #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,  // 3..255
  parameter int IMG_H = 8   // 3..255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PI,
  input  logic             PVALID,
  output logic             PREADY,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  input  logic             ACK,
  output logic             LAST
);

  // The pixel being accepted arrives on PI, so the store only needs the
  // 2*IMG_W+2 older pixels to span the full 2*IMG_W+3 window footprint.
  localparam int         c_DEPTH    = 2 * IMG_W + 2;
  localparam logic [7:0] c_COL_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] c_ROW_LAST = 8'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [7:0]                      col_q, col_d;
  logic [7:0]                      row_q, row_d;
  logic [c_DEPTH-1:0][WIDTH-1:0]   store_q, store_d;   // [0] = newest
  logic [8:0][WIDTH-1:0]           sbuf_q, sbuf_d;     // [0] = next to send
  logic [3:0]                      cnt_q, cnt_d;
  logic                            lastwin_q, lastwin_d;
  logic                            dso_q, dso_d;
  logic [WIDTH-1:0]                do_q, do_d;
  logic                            last_q, last_d;

  logic w_accept;
  logic w_win_done;
  logic w_frame_end;

  assign w_accept    = PVALID && (state_q == S_IDLE);
  // Gating purely on position means stale store contents from a previous
  // frame (or reset zeros) can never form a window.
  assign w_win_done  = (row_q >= 8'd2) && (col_q >= 8'd2);
  assign w_frame_end = (row_q == c_ROW_LAST) && (col_q == c_COL_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      store_q   <= '0;
      sbuf_q    <= '0;
      cnt_q     <= '0;
      lastwin_q <= 1'b0;
      dso_q     <= 1'b0;
      do_q      <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      store_q   <= store_d;
      sbuf_q    <= sbuf_d;
      cnt_q     <= cnt_d;
      lastwin_q <= lastwin_d;
      dso_q     <= dso_d;
      do_q      <= do_d;
      last_q    <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    store_d   = store_q;
    sbuf_d    = sbuf_q;
    cnt_d     = cnt_q;
    lastwin_d = lastwin_q;
    dso_d     = 1'b0;
    do_d      = '0;
    last_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          store_d = {store_q[c_DEPTH-2:0], PI};
          if (col_q == c_COL_LAST) begin
            col_d = '0;
            row_d = (row_q == c_ROW_LAST) ? 8'd0 : row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
          if (w_win_done) begin
            // Element 0 is P(r-2,c-2), element 8 is P(r,c) (the pixel on PI).
            sbuf_d    = {PI,
                         store_q[0],           store_q[1],
                         store_q[IMG_W-1],     store_q[IMG_W],     store_q[IMG_W+1],
                         store_q[2*IMG_W-1],   store_q[2*IMG_W],   store_q[2*IMG_W+1]};
            cnt_d     = '0;
            lastwin_d = w_frame_end;
            state_d   = S_SEND;
          end
        end
      end

      S_SEND: begin
        // Outputs are registered, so the strobe trails the state by one
        // cycle: nine data cycles, then a tenth edge that drops DSO and
        // enters WAIT. ACK is deliberately not looked at here.
        if (cnt_q == 4'd9) begin
          state_d = S_WAIT;
        end else begin
          dso_d  = 1'b1;
          do_d   = sbuf_q[0];
          last_d = lastwin_q;
          sbuf_d = {{WIDTH{1'b0}}, sbuf_q[8:1]};
          cnt_d  = cnt_q + 4'd1;
        end
      end

      S_WAIT: begin
        if (ACK) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign PREADY = (state_q == S_IDLE);
  assign DO     = do_q;
  assign DSO    = dso_q;
  assign LAST   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_window_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_tx
// Description : Directed self-checking bench for window_tx on a 4x4 image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_tx;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] PI;
  logic             PVALID;
  logic             PREADY;
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             ACK;
  logic             LAST;

  int n_total = 0;
  int n_bad   = 0;
  int idle_do_bad = 0;

  window_tx #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_dut (
    .CLK    (CLK),
    .RST    (RST),
    .PI     (PI),
    .PVALID (PVALID),
    .PREADY (PREADY),
    .DO     (DO),
    .DSO    (DSO),
    .ACK    (ACK),
    .LAST   (LAST)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; PVALID = 1'b0; ACK = 1'b0; PI = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Feed pixels 0..10 back to back; pixel 10 completes the first window.
  task automatic feed_to_first_window();
    for (int i = 0; i <= 10; i++) begin
      PVALID = 1'b1;
      PI     = 8'(i);
      step();
    end
    PVALID = 1'b0;
    PI     = '0;
  endtask

  function automatic logic [71:0] ref_win(input logic [7:0] pix[16], input int n);
    logic [71:0] v;
    int r, c;
    v = '0;
    r = 2 + n / 2;
    c = 2 + n % 2;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        v = {v[63:0], pix[(r - 2 + dr) * IMG_W + (c - 2 + dc)]};
    return v;
  endfunction

  // Stream one frame, collect every DSO burst, pulse ACK on the third cycle
  // after each WAIT entry, and compare against the expected windows.
  task automatic run_frame(input logic [7:0] pix[16], input logic [71:0] ew[4],
                           input bit toggle, input string tag);
    int          idx, nwin, k, cyc, wcnt, lc, last_bad;
    bit          waiting, phase, prev_dso, acc;
    logic [71:0] cur;
    logic [71:0] ws[4];
    logic [3:0]  last_pat;
    idx = 0; nwin = 0; k = 0; cyc = 0; wcnt = 0; lc = 0; last_bad = 0;
    waiting = 0; phase = 1; prev_dso = 0; cur = '0; last_pat = '0;
    for (int i = 0; i < 4; i++) ws[i] = '0;
    while (!(idx == 16 && nwin == 4 && !waiting && PREADY) && cyc < 800) begin
      PVALID = (idx < 16) && (!toggle || phase);
      PI     = PVALID ? pix[idx] : 8'd0;
      phase  = !phase;
      if (waiting) begin
        wcnt++;
        ACK = (wcnt == 3);
      end else begin
        ACK = 1'b0;
      end
      acc = PVALID && PREADY;
      step();
      cyc++;
      if (acc) idx++;
      if (waiting && ACK) waiting = 0;
      if (DSO) begin
        cur = {cur[63:0], DO};
        if (LAST) lc++;
        k++;
        if (k == 9) begin
          if (nwin < 4) begin
            ws[nwin]       = cur;
            last_pat[nwin] = (lc == 9);
          end
          if (lc != 0 && lc != 9) last_bad++;
          nwin++;
          k  = 0;
          lc = 0;
        end
      end else begin
        if (DO != 0) idle_do_bad++;
        if (LAST) last_bad++;
      end
      if (prev_dso && !DSO) begin
        waiting = 1;
        wcnt    = 0;
      end
      prev_dso = DSO;
    end
    ACK = 1'b0; PVALID = 1'b0; PI = '0;
    check_val({tag, "_done"}, {32'(idx), 32'(nwin)}, {32'd16, 32'd4});
    for (int n = 0; n < 4; n++)
      check_val($sformatf("%s_w%0d", tag, n), ws[n], ew[n]);
    check_val({tag, "_last"}, {32'(last_bad), 4'(last_pat)}, {32'd0, 4'b1000});
  endtask

  logic [7:0]  ramp[16];
  logic [7:0]  rnd[16];
  logic [71:0] ramp_w[4];
  logic [71:0] rnd_w[4];
  logic [10:0] dso_seq;
  logic [7:0]  do1, do9;
  logic        pr_or;

  initial begin
    RST = 1'b1; PVALID = 1'b0; ACK = 1'b0; PI = '0;
    for (int i = 0; i < 16; i++) ramp[i] = 8'(i);
    ramp_w[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8,  8'd9,  8'd10};
    ramp_w[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9,  8'd10, 8'd11};
    ramp_w[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    ramp_w[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

    // Reset state
    do_reset();
    check_val("rst_outs", {PREADY, DSO, LAST, DO}, {1'b1, 1'b0, 1'b0, 8'd0});

    // Latency, DO ordering ends, ACK ignored during SEND, PREADY after ACK
    feed_to_first_window();
    dso_seq = {10'd0, DSO};
    do1 = '0; do9 = '0; pr_or = PREADY;
    ACK = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      dso_seq = {dso_seq[9:0], DSO};
      pr_or   = pr_or | PREADY;
      if (j == 1) do1 = DO;
      if (j == 9) do9 = DO;
    end
    ACK = 1'b0;
    check_val("lat_dso_seq", 72'(dso_seq), 72'(11'b01111111110));
    check_val("lat_do_first", 72'(do1), 72'd0);
    check_val("lat_do_ninth", 72'(do9), 72'd10);
    check_val("send_pready", 72'(pr_or), 72'd0);
    repeat (2) begin
      step();
      pr_or = pr_or | PREADY;
    end
    check_val("wait_pready", {pr_or, DSO}, {1'b0, 1'b0});
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    check_val("ack_pready", 72'(PREADY), 72'd1);

    // Asynchronous reset in the 4th DSO cycle
    do_reset();
    feed_to_first_window();
    repeat (4) step();
    check_val("pre_rst_dso", {DSO, DO}, {1'b1, 8'd4});
    RST = 1'b1;
    #1;
    check_val("async_rst", {DSO, LAST, DO, PREADY}, {1'b0, 1'b0, 8'd0, 1'b1});
    step();
    RST = 1'b0;
    step();
    check_val("rel_pready", 72'(PREADY), 72'd1);

    // Fresh ramp frame, then a back-to-back ramp frame with PVALID toggling
    run_frame(ramp, ramp_w, 1'b0, "ramp");
    run_frame(ramp, ramp_w, 1'b1, "toggle");

    // Two back-to-back frames of random pixels
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom_range(0, 255));
      for (int n = 0; n < 4; n++) rnd_w[n] = ref_win(rnd, n);
      run_frame(rnd, rnd_w, 1'b0, $sformatf("rand%0d", f));
    end

    check_val("do_zero_idle", 72'(idle_do_bad), 72'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
